// File: rtl/bk_pipe_adder.sv
// bk_pipe_adder: three-stage pipelined Brent-Kung adder/subtractor, 3-cycle latency, full-rate valid/ready with
// stall-in-place backpressure; zero/neg flags exist only when BK_FLAGS_EN is defined.
module bk_pipe_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef BK_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);
  localparam int LEVELS = $clog2(WIDTH);

  logic v1, v2, v3;
  logic en1, en2, en3;
  logic accept;

  // A stage may load when it is empty or its content moves on this edge.
  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1 && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = v3;

  // ---------------- S1: operand conditioning, bitwise generate/propagate
  logic [WIDTH-1:0] bb, g_c, p_c;
  logic             c0_c;

  always_comb begin
    bb     = sub ? ~b : b;
    c0_c   = sub ? 1'b1 : cin;
    g_c    = a & bb;
    p_c    = a ^ bb;
    g_c[0] = g_c[0] | (p_c[0] & c0_c);
  end

  logic [WIDTH-1:0] s1_g, s1_p;
  logic             s1_c0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      s1_g  <= '0;
      s1_p  <= '0;
      s1_c0 <= 1'b0;
    end else begin
      if (en1) v1 <= accept;
      if (accept) begin
        s1_g  <= g_c;
        s1_p  <= p_c;
        s1_c0 <= c0_c;
      end
    end
  end

  // ---------------- S2: up-sweep of black cells on spans 2, 4, ..., WIDTH
  logic [WIDTH-1:0] up_g, up_p;

  always_comb begin : up_sweep
    logic [WIDTH-1:0] gg, pp;
    gg = s1_g;
    pp = s1_p;
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i + 1) % (2 << l) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
    up_g = gg;
    up_p = pp;
  end

  logic [WIDTH-1:0] s2_g, s2_pg, s2_p;
  logic             s2_c0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2    <= 1'b0;
      s2_g  <= '0;
      s2_pg <= '0;
      s2_p  <= '0;
      s2_c0 <= 1'b0;
    end else begin
      if (en2) v2 <= v1;
      if (en2 && v1) begin
        s2_g  <= up_g;
        s2_pg <= up_p;
        s2_p  <= s1_p;
        s2_c0 <= s1_c0;
      end
    end
  end

  // ---------------- S3: grey-cell down-sweep, then sum and status
  // Node i takes its span-d group (held in s2_pg) and the full prefix just below it.
  logic [WIDTH-1:0] carry, sum_c;
  logic             cout_c, ovf_c;

  always_comb begin : down_sweep
    logic [WIDTH-1:0] cc;
    cc = s2_g;
    for (int l = LEVELS - 2; l >= 0; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (2 << l) == (1 << l)) && (i + 1 >= 3 * (1 << l))) begin
          cc[i] = cc[i] | (s2_pg[i] & cc[i - (1 << l)]);
        end
      end
    end
    carry  = cc;
    sum_c  = s2_p ^ {carry[WIDTH-2:0], s2_c0};
    cout_c = carry[WIDTH-1];
    ovf_c  = carry[WIDTH-1] ^ carry[WIDTH-2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
`ifdef BK_FLAGS_EN
      zero <= 1'b0;
      neg  <= 1'b0;
`endif
    end else begin
      if (en3) v3 <= v2;
      if (en3 && v2) begin
        sum  <= sum_c;
        cout <= cout_c;
        ovf  <= ovf_c;
`ifdef BK_FLAGS_EN
        zero <= (sum_c == '0);
        neg  <= sum_c[WIDTH-1];
`endif
      end
    end
  end

endmodule
